// File: rtl/cache_linefill.sv
// Cache line refill/evict engine: optionally writes the dirty victim line back to the bus,
// then bursts the new line from main memory into the byte-banked line memory.
module cache_linefill #(
  parameter int ADDRBITS    = 32,
  parameter int DATABITS    = 32,
  parameter int LSBBITS     = 7,
  parameter int WORDLENBITS = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fill_req,
  input  logic [ADDRBITS-1:0]    fill_addr,
  input  logic                   fill_dirty,
  input  logic [ADDRBITS-1:0]    fill_wbaddr,
  output logic                   fill_busy,
  output logic                   fill_done,
  output logic [LSBBITS-1:0]     line_mem_wraddr,
  output logic                   line_mem_we,
  output logic [DATABITS-1:0]    line_mem_in,
  output logic [WORDLENBITS-1:0] line_mem_in_wordlen,
  output logic [LSBBITS-1:0]     line_mem_rdaddr,
  input  logic [DATABITS-1:0]    line_mem_out,
  output logic [ADDRBITS-1:0]    mem_addr,
  output logic                   mem_rd,
  output logic                   mem_wr,
  output logic [DATABITS-1:0]    mem_wdata,
  input  logic                   mem_ack,
  input  logic [DATABITS-1:0]    mem_rdata,
  input  logic                   mem_rdata_valid,
  output logic [2:0]             state_dbg
);

  localparam int CW = LSBBITS - 2;
  localparam int TW = ADDRBITS - LSBBITS;
  localparam logic [CW-1:0] LAST = '1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WB_RD = 3'd1;
  localparam logic [2:0] WB_WR = 3'd2;
  localparam logic [2:0] FILL  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  // Handshake: mem_rd/mem_wr with mem_addr (and mem_wdata) are held stable until the
  // cycle mem_ack is high; read data returns later, in order, flagged by mem_rdata_valid.
  logic [2:0]    state;
  logic [TW-1:0] base;
  logic [TW-1:0] wbbase;
  logic [CW-1:0] wb_cnt;
  logic [CW-1:0] iss_cnt;
  logic          iss_done;
  logic [CW-1:0] rx_cnt;

  logic unused_low_bits;
  assign unused_low_bits = ^{fill_addr[LSBBITS-1:0], fill_wbaddr[LSBBITS-1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      base     <= '0;
      wbbase   <= '0;
      wb_cnt   <= '0;
      iss_cnt  <= '0;
      iss_done <= 1'b0;
      rx_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fill_req) begin
            base   <= fill_addr[ADDRBITS-1:LSBBITS];
            wbbase <= fill_wbaddr[ADDRBITS-1:LSBBITS];
            state  <= fill_dirty ? WB_RD : FILL;
          end
        end
        WB_RD: state <= WB_WR;
        WB_WR: begin
          if (mem_ack) begin
            if (wb_cnt == LAST) begin
              wb_cnt <= '0;
              state  <= FILL;
            end else begin
              wb_cnt <= wb_cnt + 1'b1;
              state  <= WB_RD;
            end
          end
        end
        FILL: begin
          // Issue and receive sides advance independently; both may move in one cycle.
          if (mem_ack && !iss_done) begin
            if (iss_cnt == LAST) iss_done <= 1'b1;
            else iss_cnt <= iss_cnt + 1'b1;
          end
          if (mem_rdata_valid) begin
            if (rx_cnt == LAST) state <= DONE;
            else rx_cnt <= rx_cnt + 1'b1;
          end
        end
        DONE: begin
          // Counters return to zero here so idle outputs rest at zero.
          iss_cnt  <= '0;
          iss_done <= 1'b0;
          rx_cnt   <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    line_mem_we = 1'b0;
    line_mem_in = '0;
    case (state)
      WB_WR: begin
        mem_wr    = 1'b1;
        mem_addr  = {wbbase, wb_cnt, 2'b00};
        mem_wdata = line_mem_out;
      end
      FILL: begin
        mem_rd = !iss_done;
        if (!iss_done) mem_addr = {base, iss_cnt, 2'b00};
        if (mem_rdata_valid) begin
          line_mem_we = 1'b1;
          line_mem_in = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  // Read address is held through WB_WR so the registered line memory output stays valid.
  assign line_mem_rdaddr     = {wb_cnt, 2'b00};
  assign line_mem_wraddr     = {rx_cnt, 2'b00};
  assign line_mem_in_wordlen = WORDLENBITS'(2);
  assign fill_busy           = (state != IDLE);
  assign fill_done           = (state == DONE);
  assign state_dbg           = state;

endmodule
